// File: rtl/cd_arbiter_pkg.sv
// Shared types for the counter/detector arbiter: FSM state encoding,
// requester id and default timeout.
package cd_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_WAIT_BUSY  = 3'd2,
    S_WAIT_READY = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  typedef logic req_id_t;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/cd_rr_pick.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that did not own the last run.
module cd_rr_pick
  import cd_arbiter_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last,
  output logic    valid,
  output req_id_t winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/cd_arbiter.sv
// Round-robin arbiter/sequencer sharing one counter-and-detector unit between
// two requesters. Optional run timeout with abort: CD_ARBITER_TIMEOUT_EN.
module cd_arbiter
  import cd_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic unit_ready,
  output logic unit_start,
  output logic unit_abort,
  output logic sel,
  output logic gnt0,
  output logic gnt1,
  output logic done0,
  output logic done1,
  output logic err,
  output logic busy
);

  state_t  state, state_nx;
  req_id_t owner, last, win;
  logic    valid, to_hit, waiting;

  cd_rr_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .valid  (valid),
    .winner (win)
  );

  assign waiting = (state == S_WAIT_BUSY) || (state == S_WAIT_READY);

`ifdef CD_ARBITER_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT));

  // to_flag marks a DONE reached by expiry; DONE lasts one cycle so it self-clears
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state_nx == S_START) to_cnt <= '0;
      else if (waiting)        to_cnt <= to_cnt + 1'b1;
      to_flag <= waiting && to_hit;
    end
  end

  assign err        = (state == S_DONE) && to_flag;
  assign unit_abort = err;
`else
  assign to_hit     = 1'b0;
  assign err        = 1'b0;
  assign unit_abort = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       if (valid && unit_ready) state_nx = S_START;
      S_START:      state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY:  if (to_hit) state_nx = S_DONE;
                    else if (!unit_ready) state_nx = S_WAIT_READY;
      S_WAIT_READY: if (to_hit || unit_ready) state_nx = S_DONE;
      S_DONE:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      sel   <= 1'b0;
    end else begin
      state <= state_nx;
      // requests are only sampled here; sel then holds through the following IDLE
      if (state == S_IDLE && state_nx == S_START) begin
        owner <= win;
        sel   <= win;
      end
      if (state == S_DONE) last <= owner;
    end
  end

  assign busy       = (state != S_IDLE);
  assign unit_start = (state == S_START);
  assign gnt0       = busy && (owner == 1'b0);
  assign gnt1       = busy && (owner == 1'b1);
  assign done0      = (state == S_DONE) && (owner == 1'b0);
  assign done1      = (state == S_DONE) && (owner == 1'b1);

endmodule

// File: tb/tb_cd_arbiter.sv
// Randomized bench for cd_arbiter: a behavioural unit drives unit_ready and a
// run-level reference model predicts every output each cycle.
module tb_cd_arbiter;

`ifdef CD_ARBITER_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  logic rst, req0, req1, unit_ready;
  logic unit_start, unit_abort, sel, gnt0, gnt1, done0, done1, err, busy;

  int n_chk = 0;
  int n_fail = 0;

  cd_arbiter #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .unit_ready(unit_ready),
    .unit_start(unit_start), .unit_abort(unit_abort), .sel(sel),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a run is granted, pulses start, waits for the unit to go busy
  // then idle again (or for expiry), reports completion, then idles a cycle.
  bit m_run, m_start, m_done, m_err, m_low, m_owner, m_last;
  int m_age;

  task automatic model_step(input bit r, input bit r0, input bit r1, input bit rdy);
    if (r) begin
      m_run = 0; m_start = 0; m_done = 0; m_err = 0; m_owner = 0; m_last = 1;
    end else if (m_done) begin
      m_last = m_owner; m_run = 0; m_done = 0; m_err = 0;
    end else if (!m_run) begin
      if ((r0 || r1) && rdy) begin
        m_owner = (r0 && r1) ? !m_last : r1;
        m_run = 1; m_start = 1; m_low = 0; m_age = 0;
      end
    end else if (m_start) begin
      m_start = 0;
    end else begin
`ifdef CD_ARBITER_TIMEOUT_EN
      if (m_age == TO) begin
        m_done = 1; m_err = 1;
      end else begin
`else
      begin
`endif
        if (!m_low) begin
          if (!rdy) m_low = 1;
        end else if (rdy) begin
          m_done = 1;
        end
        m_age++;
      end
    end
  endtask

  function automatic logic [8:0] expected();
    return {m_run && !m_owner, m_run && m_owner, m_start,
            m_done && !m_owner, m_done && m_owner, m_owner, m_run, m_err, m_err};
  endfunction

  initial begin
    int  ucnt;
    bit  p_start, p_abort, p_busy;
    int  runs0, runs1;
    rst = 1; req0 = 1; req1 = 1; unit_ready = 1;
    ucnt = 0; p_start = 0; p_abort = 0; p_busy = 0; runs0 = 0; runs1 = 0;
    m_owner = 0; m_last = 1; m_age = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_step(rst, req0, req1, unit_ready);
      chk($sformatf("outs@%0d", cyc),
          32'({gnt0, gnt1, unit_start, done0, done1, sel, busy, err, unit_abort}),
          32'(expected()));
      if (done0) runs0++;
      if (done1) runs1++;

      // unit: goes busy the edge after it sees start, idle again later
      if (rst || p_abort) begin
        unit_ready = 1; ucnt = 0;
      end else if (p_start) begin
        unit_ready = 0;
`ifdef CD_ARBITER_TIMEOUT_EN
        ucnt = ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(1, 6);
`else
        ucnt = $urandom_range(1, 6);
`endif
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) unit_ready = 1;
      end else if (!p_busy && $urandom_range(0, 19) == 0) begin
        unit_ready = 0; ucnt = $urandom_range(1, 4);
      end
      p_start = unit_start; p_abort = unit_abort; p_busy = busy;

      // requesters: hold until done, occasionally drop mid-run
      if (done0)      req0 = 1'($urandom_range(0, 1));
      else if (!req0) req0 = ($urandom_range(0, 3) == 0);
      else if (gnt0 && $urandom_range(0, 29) == 0) req0 = 0;
      if (done1)      req1 = 1'($urandom_range(0, 1));
      else if (!req1) req1 = ($urandom_range(0, 3) == 0);
      else if (gnt1 && $urandom_range(0, 29) == 0) req1 = 0;

      if (cyc < 1) rst = 1;
      else rst = ($urandom_range(0, 99) == 0);
    end
    chk("runs0_seen", 32'(runs0 > 10), 32'd1);
    chk("runs1_seen", 32'(runs1 > 10), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
